sram_like_arbiter: RTL and testbench

- Shares one sram-like memory master port between the instruction-fetch and data-access sram-like request ports of the core.
- Sits between the IF/MEM stages and the external bus bridge.
- Allows one outstanding transaction at a time.
- Data side has fixed priority, with a bounded anti-starvation guarantee for fetch.

---
 rtl/sram_like_arbiter_pkg.sv | 24 ++
 rtl/sram_like_arbiter_if.sv | 26 ++
 rtl/sram_like_arbiter_req_mux.sv | 18 +
 rtl/sram_like_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared types and constants for the sram-like arbiter
package sram_like_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } sram_like_req_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - sram-like request/response port bundle
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  // Side that issues requests
  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests
  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter_req_mux.sv
// rtl/sram_like_arbiter_req_mux.sv - 2:1 selector of request bundles
module sram_like_req_mux
  import sram_like_arbiter_pkg::*;
#(
  parameter type req_t = sram_like_req_t
) (
  input  logic sel,
  input  req_t in_inst,
  input  req_t in_data,
  output req_t req_o
);

  // Forward the bundle of whichever requester currently owns the bus
  always_comb begin
    req_o = (sel == OWNER_DATA) ? in_data : in_inst;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one sram-like master port between fetch and data
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_like_arbiter_if.slave   inst_if,
  sram_like_arbiter_if.slave   data_if,
  sram_like_arbiter_if.master  m_if
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic sel;
  logic bus_active;
  logic handshake;
  logic inst_addr_ok, data_addr_ok;
  logic inst_data_ok, data_data_ok;
  req_t inst_r, data_r, mux_r;

  assign inst_r = '{req: inst_if.req, wr: inst_if.wr, size: inst_if.size,
                    addr: inst_if.addr, wdata: inst_if.wdata};
  assign data_r = '{req: data_if.req, wr: data_if.wr, size: data_if.size,
                    addr: data_if.addr, wdata: data_if.wdata};

  sram_like_req_mux #(.req_t(req_t)) u_req_mux (
    .sel     (sel),
    .in_inst (inst_r),
    .in_data (data_r),
    .req_o   (mux_r)
  );

  // Arbitration, next state, starvation counter and handshake steering
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    sel          = owner_q;
    bus_active   = 1'b0;
    handshake    = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          // Data wins unless fetch has been passed over STARVE_LIMIT times
          if (data_if.req && !(inst_if.req && starve_cnt_q == CNT_MAX)) begin
            sel        = OWNER_DATA;
            bus_active = 1'b1;
          end else if (inst_if.req) begin
            sel        = OWNER_INST;
            bus_active = 1'b1;
          end
          if (bus_active) begin
            owner_d   = sel;
            handshake = m_if.addr_ok;
            state_d   = m_if.addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          // Grant is locked to the owner until the slave takes the address
          bus_active = 1'b1;
          handshake  = m_if.addr_ok;
          if (m_if.addr_ok) state_d = DATA;
        end
        DATA: begin
          if (m_if.data_ok) begin
            inst_data_ok = (owner_q == OWNER_INST);
            data_data_ok = (owner_q == OWNER_DATA);
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (handshake) begin
        if (sel == OWNER_INST) begin
          starve_cnt_d = '0;
        end else if (inst_if.req && starve_cnt_q != CNT_MAX) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
    end

    inst_addr_ok = bus_active && (sel == OWNER_INST) && m_if.addr_ok;
    data_addr_ok = bus_active && (sel == OWNER_DATA) && m_if.addr_ok;
  end

  // State, owner and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_INST;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A requester holding the address phase must keep its request up
  always_ff @(posedge clk) begin
    if (!rst && state_q == ADDR) begin
      assert (owner_q == OWNER_DATA ? data_if.req : inst_if.req);
    end
  end

  assign m_if.req   = bus_active & mux_r.req;
  assign m_if.wr    = bus_active & mux_r.wr;
  assign m_if.size  = bus_active ? mux_r.size  : '0;
  assign m_if.addr  = bus_active ? mux_r.addr  : '0;
  assign m_if.wdata = bus_active ? mux_r.wdata : '0;

  assign inst_if.addr_ok = inst_addr_ok;
  assign data_if.addr_ok = data_addr_ok;
  assign inst_if.data_ok = inst_data_ok;
  assign data_if.data_ok = data_data_ok;
  assign inst_if.rdata   = m_if.rdata;
  assign data_if.rdata   = m_if.rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed vector bench for sram_like_arbiter
module tb_sram_like_arbiter;

  localparam logic [31:0] INST_ADDR  = 32'hBFC00000;
  localparam logic [31:0] INST_WDATA = 32'h11110000;
  localparam logic [31:0] DATA_ADDR  = 32'h80000010;
  localparam logic [31:0] DATA_WDATA = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .inst_if (inst_if),
    .data_if (data_if),
    .m_if    (m_if)
  );

  // who: 0 = no grant, 1 = inst on the bus, 2 = data on the bus
  typedef struct {
    string       name;
    bit          rst, ireq, dreq, dwr, aok, dok;
    logic [31:0] rdata;
    bit          e_mreq;
    int          e_who;
    bit          e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input bit r, input bit ireq, input bit dreq, input bit dwr,
                       input bit aok, input bit dok, input logic [31:0] rd);
    rst           = r;
    inst_if.req   = ireq;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.addr  = INST_ADDR;
    inst_if.wdata = INST_WDATA;
    data_if.req   = dreq;
    data_if.wr    = dwr;
    data_if.size  = 2'd1;
    data_if.addr  = DATA_ADDR;
    data_if.wdata = DATA_WDATA;
    m_if.addr_ok  = aok;
    m_if.data_ok  = dok;
    m_if.rdata    = rd;
  endtask

  task automatic check(input string name, input bit e_mreq, input int who, input bit e_wr,
                       input bit e_iaok, input bit e_daok, input bit e_idok, input bit e_ddok);
    logic [71:0] act, exp;
    logic [31:0] ea, ew;
    logic [1:0]  es;
    logic        ewr;
    ea = '0; ew = '0; es = '0; ewr = 1'b0;
    if (who == 1) begin
      ea = INST_ADDR; ew = INST_WDATA; es = 2'd2;
    end else if (who == 2) begin
      ea = DATA_ADDR; ew = DATA_WDATA; es = 2'd1; ewr = e_wr;
    end
    exp = {e_mreq, ewr, es, ea, ew, e_iaok, e_daok, e_idok, e_ddok};
    act = {m_if.req, m_if.wr, m_if.size, m_if.addr, m_if.wdata,
           inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end
    tests++;
    if ({inst_if.rdata, data_if.rdata} !== {m_if.rdata, m_if.rdata}) begin
      fails++;
      $display("FAIL %s_rdata: got %h/%h expected %h", name, inst_if.rdata, data_if.rdata, m_if.rdata);
    end
  endtask

  initial begin
    //          name           rst ireq dreq dwr aok dok rdata          mreq who ia da id dd
    vq.push_back('{"rst_idle",      1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0});
    vq.push_back('{"rst_with_req",  1, 1, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0});
    vq.push_back('{"fetch_addr",    0, 1, 0, 0, 1, 0, 32'h0,        1, 1, 1, 0, 0, 0});
    vq.push_back('{"fetch_data",    0, 0, 0, 0, 0, 1, 32'h3C1D0000, 0, 0, 0, 0, 1, 0});
    vq.push_back('{"idle_quiet",    0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0});
    vq.push_back('{"spurious_idle", 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0});
    vq.push_back('{"coll_addr",     0, 1, 1, 1, 1, 0, 32'h0,        1, 2, 0, 1, 0, 0});
    vq.push_back('{"coll_data",     0, 1, 0, 0, 0, 1, 32'h0000BEEF, 0, 0, 0, 0, 0, 1});
    vq.push_back('{"coll_inst",     0, 1, 0, 0, 1, 0, 32'h0,        1, 1, 1, 0, 0, 0});
    vq.push_back('{"coll_inst_d",   0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0, 0, 0, 0, 1, 0});
    vq.push_back('{"hold_c0",       0, 1, 0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0});
    vq.push_back('{"hold_c1",       0, 1, 1, 1, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0});
    vq.push_back('{"hold_c2",       0, 1, 1, 1, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0});
    vq.push_back('{"hold_c3",       0, 1, 1, 1, 1, 0, 32'h0,        1, 1, 1, 0, 0, 0});
    vq.push_back('{"hold_idata",    0, 0, 1, 1, 0, 1, 32'h00C0FFEE, 0, 0, 0, 0, 1, 0});
    vq.push_back('{"hold_daddr",    0, 0, 1, 1, 1, 0, 32'h0,        1, 2, 0, 1, 0, 0});
    vq.push_back('{"hold_ddata",    0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 1});
    vq.push_back('{"spur_addr",     0, 1, 0, 0, 0, 1, 32'h55AA55AA, 1, 1, 0, 0, 0, 0});
    vq.push_back('{"spur_addr_ok",  0, 1, 0, 0, 1, 0, 32'h0,        1, 1, 1, 0, 0, 0});
    vq.push_back('{"spur_data",     0, 0, 0, 0, 0, 1, 32'h77777777, 0, 0, 0, 0, 1, 0});
    vq.push_back('{"rstd_addr",     0, 0, 1, 1, 1, 0, 32'h0,        1, 2, 0, 1, 0, 0});
    vq.push_back('{"rstd_pulse",    1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0});
    vq.push_back('{"rstd_late_rsp", 0, 0, 0, 0, 0, 1, 32'h99999999, 0, 0, 0, 0, 0, 0});
    vq.push_back('{"rstd_after",    0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0});

    drive(1, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ireq, vq[i].dreq, vq[i].dwr, vq[i].aok, vq[i].dok, vq[i].rdata);
      #2;
      check(vq[i].name, vq[i].e_mreq, vq[i].e_who, vq[i].dwr,
            vq[i].e_iaok, vq[i].e_daok, vq[i].e_idok, vq[i].e_ddok);
      @(negedge clk);
    end

    // Starvation: both requesters held, four data wins then fetch is forced through
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      int who;
      who = (k == 4) ? 1 : 2;
      drive(0, 1, 1, 1, 1, 0, 32'h0);
      #2;
      check($sformatf("starve_addr%0d", k), 1, who, 1, who == 1, who == 2, 0, 0);
      @(negedge clk);
      drive(0, 1, 1, 1, 0, 1, 32'hA5000000 + k);
      #2;
      check($sformatf("starve_data%0d", k), 0, 0, 0, 0, 0, who == 1, who == 2);
      @(negedge clk);
    end

    drive(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
